// File: rtl/cam_capture.sv
// OV7670 RGB565 capture: synchronises the camera bus into clk_25m,
// pairs bytes into pixels and writes them linearly into the frame buffer.
module cam_capture #(
  parameter int H_PIX       = 320,
  parameter int V_LINE      = 240,
  parameter int SKIP_FRAMES = 2,
  parameter int ADDR_W      = 17
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic              init_done,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              cap_err
);

  localparam int NPIX = H_PIX * V_LINE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam int XW = $clog2(H_PIX + 2) + 1;
  localparam logic [XW-1:0] X_LIM = XW'(H_PIX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic       r_pclk_m, r_pclk_s, r_pclk_d;
  logic       r_vs_m, r_vs_s, r_vs_d;
  logic       r_href_m, r_href_s, r_href_d;
  logic [7:0] r_data_m, r_data_s;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_frame_done;
  logic              r_cap_err;

  logic [3:0]        r_skip_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic              r_phase;
  logic              r_full;
  logic [7:0]        r_hi;

  logic w_pclk_rise;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_fall;
  logic w_skip_inc;
  logic w_start;
  logic w_frame_end;
  logic w_take;
  logic w_line_end;

  // data shares the pclk pipeline depth so a detected edge sees its byte
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_pclk_m <= 1'b0;
      r_pclk_s <= 1'b0;
      r_pclk_d <= 1'b0;
      r_vs_m   <= 1'b0;
      r_vs_s   <= 1'b0;
      r_vs_d   <= 1'b0;
      r_href_m <= 1'b0;
      r_href_s <= 1'b0;
      r_href_d <= 1'b0;
      r_data_m <= 8'd0;
      r_data_s <= 8'd0;
    end else begin
      r_pclk_m <= cam_pclk;
      r_pclk_s <= r_pclk_m;
      r_pclk_d <= r_pclk_s;
      r_vs_m   <= cam_vsync;
      r_vs_s   <= r_vs_m;
      r_vs_d   <= r_vs_s;
      r_href_m <= cam_href;
      r_href_s <= r_href_m;
      r_href_d <= r_href_s;
      r_data_m <= cam_data;
      r_data_s <= r_data_m;
    end
  end

  assign w_pclk_rise = r_pclk_s & ~r_pclk_d;
  assign w_vs_rise   = r_vs_s & ~r_vs_d;
  assign w_vs_fall   = ~r_vs_s & r_vs_d;
  assign w_href_fall = ~r_href_s & r_href_d;

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_inc  = 1'b0;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    w_take      = 1'b0;
    w_line_end  = 1'b0;
    if (!init_done) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_WAIT_VS;
        S_WAIT_VS: begin
          if (w_vs_rise) begin
            if (r_skip_cnt == 4'(SKIP_FRAMES)) w_state_nxt = S_ARMED;
            else                               w_skip_inc  = 1'b1;
          end
        end
        S_ARMED: begin
          if (w_vs_fall) begin
            w_state_nxt = S_CAPTURE;
            w_start     = 1'b1;
          end
        end
        S_CAPTURE: begin
          // end of frame outranks a byte arriving in the same cycle
          if (w_vs_rise) begin
            w_state_nxt = S_ARMED;
            w_frame_end = 1'b1;
          end else begin
            w_take     = w_pclk_rise & r_href_s;
            w_line_end = w_href_fall;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_skip_cnt <= 4'd0;
    end else if (!init_done) begin
      r_skip_cnt <= 4'd0;
    end else if (w_skip_inc) begin
      r_skip_cnt <= r_skip_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 16'd0;
      r_frame_done <= 1'b0;
      r_cap_err    <= 1'b0;
      r_addr       <= '0;
      r_x          <= '0;
      r_phase      <= 1'b0;
      r_full       <= 1'b0;
      r_hi         <= 8'd0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= w_frame_end;
      if (w_start) begin
        r_addr  <= '0;
        r_x     <= '0;
        r_phase <= 1'b0;
        r_full  <= 1'b0;
      end else if (!init_done || w_frame_end) begin
        r_phase <= 1'b0;
      end else if (w_take) begin
        if (!r_phase) begin
          r_hi    <= r_data_s;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          // saturate just past H_PIX so an overlong line never aliases back
          if (r_x <= X_LIM) r_x <= r_x + XW'(1);
          if (r_full) begin
            r_cap_err <= 1'b1;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= {r_hi, r_data_s};
            if (r_addr == LAST) r_full <= 1'b1;
            else                r_addr <= r_addr + ADDR_W'(1);
          end
        end
      end else if (w_line_end) begin
        if (r_x != X_LIM) r_cap_err <= 1'b1;
        r_x     <= '0;
        r_phase <= 1'b0;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign cap_err    = r_cap_err;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a reduced 8x4 frame: scenario table plus
// random pixel data checked against a frame-level pixel model.
module tb_cam_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int AW   = 5;
  localparam logic [AW-1:0] LAST = AW'(H * V - 1);

  logic          clk_25m = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          cap_err;

  cam_capture #(
    .H_PIX(H), .V_LINE(V), .SKIP_FRAMES(SKIP), .ADDR_W(AW)
  ) dut (
    .clk_25m(clk_25m), .rst(rst), .init_done(init_done),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .cap_err(cap_err)
  );

  always #5 clk_25m = ~clk_25m;

  typedef struct {
    int init;
    int nframes;
    int nlines;
    int nbytes;
    int odd_line;
    int odd_bytes;
    int exp_wr;
    int exp_fd;
    int exp_err;
  } vec_t;

  vec_t tbl [6];

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int g_frame = 0;
  bit mdl_init = 0;
  bit mdl_full = 0;
  logic [AW-1:0] mdl_addr = '0;
  logic [AW+15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_25m) begin
    if (!rst) begin
      if (wr_en) begin
        wr_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %h expected none",
                   wr_addr, wr_data);
        end else begin
          logic [AW+15:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_err++;
            $display("FAIL pixel: got %0d/%h expected %0d/%h",
                     wr_addr, wr_data, e[AW+15:16], e[15:0]);
          end
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_line(input int nb, input bit cap);
    logic [7:0] b [64];
    for (int i = 0; i < nb; i++) b[i] = 8'($urandom);
    if (cap && mdl_init) begin
      for (int p = 0; p < nb / 2; p++) begin
        if (!mdl_full) begin
          exp_q.push_back({mdl_addr, b[2*p], b[2*p+1]});
          if (mdl_addr == LAST) mdl_full = 1;
          else                  mdl_addr++;
        end
      end
    end
    cam_href = 1'b1;
    for (int i = 0; i < nb; i++) begin
      cam_data = b[i];
      cam_pclk = 1'b0;
      repeat (2) @(negedge clk_25m);
      cam_pclk = 1'b1;
      repeat (2) @(negedge clk_25m);
    end
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk_25m);
    cam_href = 1'b0;
    repeat (6) @(negedge clk_25m);
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk_25m);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk_25m);
  endtask

  task automatic drive_frame(input int nl, input int nb,
                             input int odd_l, input int odd_b);
    bit cap;
    cap = mdl_init && (g_frame >= SKIP);
    vs_pulse();
    mdl_addr = '0;
    mdl_full = 0;
    for (int l = 0; l < nl; l++)
      send_line((l == odd_l) ? odd_b : nb, cap);
    g_frame++;
  endtask

  task automatic do_reset();
    @(negedge clk_25m);
    rst = 1'b1;
    init_done = 1'b0;
    mdl_init = 0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'd0;
    repeat (3) @(negedge clk_25m);
    rst = 1'b0;
    repeat (2) @(negedge clk_25m);
    exp_q.delete();
  endtask

  task automatic run_entry(input vec_t v, input bit with_rst, input string tag);
    if (with_rst) do_reset();
    wr_cnt = 0;
    fd_cnt = 0;
    g_frame = 0;
    init_done = v.init[0];
    mdl_init = v.init[0];
    repeat (4) @(negedge clk_25m);
    for (int f = 0; f < v.nframes; f++)
      drive_frame(v.nlines, v.nbytes, v.odd_line, v.odd_bytes);
    vs_pulse();
    check({tag, "_writes"}, wr_cnt, v.exp_wr);
    check({tag, "_frame_done"}, fd_cnt, v.exp_fd);
    check({tag, "_cap_err"}, {31'd0, cap_err}, v.exp_err);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{0, 3, 4, 16, -1, 0,  0, 0, 0};
    tbl[1] = '{1, 4, 4, 16, -1, 0, 64, 2, 0};
    tbl[2] = '{1, 3, 4, 16,  1, 18, 32, 1, 1};
    tbl[3] = '{1, 3, 5, 16, -1, 0, 32, 1, 1};
    tbl[4] = '{1, 3, 4, 16,  2, 15, 31, 1, 1};
    tbl[5] = '{1, 3, 3, 16, -1, 0, 24, 1, 0};

    repeat (2) @(negedge clk_25m);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_addr", {27'd0, wr_addr}, 0);
    check("rst_wr_data", {16'd0, wr_data}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_cap_err", {31'd0, cap_err}, 0);

    for (int t = 0; t < 6; t++)
      run_entry(tbl[t], 1'b1, $sformatf("t%0d", t));

    // init_done dropped mid-line in the first captured frame
    do_reset();
    wr_cnt = 0;
    fd_cnt = 0;
    g_frame = 0;
    init_done = 1'b1;
    mdl_init = 1;
    repeat (4) @(negedge clk_25m);
    fork
      for (int f = 0; f < 3; f++) drive_frame(4, 16, -1, 0);
      begin
        int i;
        for (i = 0; i < 5000 && wr_cnt < 12; i++) @(negedge clk_25m);
        if (wr_cnt < 12) begin
          n_chk++;
          n_err++;
          $display("FAIL drop_wait: got %0d writes expected 12", wr_cnt);
        end
        init_done = 1'b0;
        mdl_init = 0;
        exp_q.delete();
        @(negedge clk_25m);
        check("drop_wr_en", {31'd0, wr_en}, 0);
      end
    join
    vs_pulse();
    check("drop_writes", wr_cnt, 12);
    check("drop_frame_done", fd_cnt, 0);
    run_entry(tbl[1], 1'b0, "redo");

    // asynchronous reset in the middle of a captured frame
    do_reset();
    g_frame = 0;
    init_done = 1'b1;
    mdl_init = 1;
    repeat (4) @(negedge clk_25m);
    drive_frame(4, 16, -1, 0);
    drive_frame(4, 16, -1, 0);
    wr_cnt = 0;
    drive_frame(2, 16, 0, 15);
    check("pre_rst_writes", wr_cnt, 15);
    check("pre_rst_cap_err", {31'd0, cap_err}, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_wr_en", {31'd0, wr_en}, 0);
    check("rst_mid_wr_addr", {27'd0, wr_addr}, 0);
    check("rst_mid_wr_data", {16'd0, wr_data}, 0);
    check("rst_mid_frame_done", {31'd0, frame_done}, 0);
    check("rst_mid_cap_err", {31'd0, cap_err}, 0);
    init_done = 1'b0;
    mdl_init = 0;
    exp_q.delete();
    repeat (2) @(negedge clk_25m);
    rst = 1'b0;
    repeat (2) @(negedge clk_25m);
    run_entry(tbl[5], 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
